shim_spi_sts_sync: RTL and testbench
====================================

Name: shim_spi_sts_sync

Overview:
Status return path from the SPI clock domain to the AXI clock domain. It is the counterpart of the configuration synchronizer that moves AXI config into the SPI domain. It samples SPI-domain status and fault signals, which are asynchronous to aclk. Each field passes through a multi-flop synchronizer and a per-field stability filter before being registered, and fault bits are latched sticky until software clears them. Outputs feed the AXI status register block.

Parameters:
DEPTH, 3, synchronizer flop stages per field (min 2)
STABLE_COUNT, 2, consecutive equal cycles required before a field is accepted (min 1)
N_CH, 8, number of DAC/integrator channels

Ports:
aclk  input  1  AXI-domain clock; the block's only clock
aresetn  input  1  asynchronous active-low reset
spi_running  input  1  SPI core running (SPI domain)
over_thresh  input  N_CH  integrator over-threshold per channel (SPI domain)
thresh_underflow  input  N_CH  integrator underflow per channel (SPI domain)
thresh_overflow  input  N_CH  integrator overflow per channel (SPI domain)
bad_trig_cmd  input  1  illegal trigger command seen (SPI domain)
buf_words  input  16  command buffer fill level (SPI domain)
sts_clear  input  1  AXI-domain pulse; clears sticky faults
spi_running_stable  output  1  filtered spi_running
over_thresh_stable  output  N_CH  filtered over_thresh
buf_words_stable  output  16  filtered buf_words
fault_sticky  output  3*N_CH+1  latched faults {bad_trig_cmd, thresh_overflow, thresh_underflow, over_thresh}, LSB = over_thresh[0]
fault_any  output  1  OR of fault_sticky
sts_update  output  1  one-cycle pulse when any *_stable output or fault_sticky changes

Behaviour:
- Fields are filtered independently: spi_running, over_thresh, thresh_underflow, thresh_overflow, bad_trig_cmd, buf_words.
- Per-field pipeline:
  - sync[0..DEPTH-1] shift chain; last = sync[DEPTH-1].
  - prev <= last every cycle.
  - equal = (last == prev), compared over the whole field.
  - cnt: if !equal then 0; else if cnt < STABLE_COUNT then cnt+1; cnt saturates.
  - flag = equal && cnt == STABLE_COUNT.
  - The field's stable register loads last when flag is high.
- The full multi-bit field is accepted atomically, so no torn words reach the outputs.
- Latency: an input change held constant appears on its stable output DEPTH+STABLE_COUNT+1 aclk edges after the first edge that samples it. With defaults this is 6 edges.
- A field that changes more often than every STABLE_COUNT+1 cycles never passes the filter. Its output holds the last accepted value indefinitely.
- Internal filtered copies of thresh_underflow, thresh_overflow and bad_trig_cmd are used only for sticky latching and are not exported.
- Sticky latching: fault_sticky[i] <= (fault_sticky[i] & ~sts_clear) | filtered_fault[i].
  - Set wins over clear in the same cycle.
  - The clear takes effect on the edge that samples sts_clear high.
- fault_any is registered and follows fault_sticky with one cycle of latency.
- sts_update is registered. It is high for the one cycle after any stable output or fault_sticky bit changes. Multiple changes in the same cycle produce one pulse.
- Reset (aresetn low, asynchronous assert, synchronous deassert handled upstream) clears:
  - all sync stages, prev, and cnt to 0;
  - all outputs to 0.
- After reset release, outputs stay 0 until each field passes its filter.
- Reset asserted mid-filter discards partial counts.

Optional Feature:
Macro SHIM_STS_FIRST_FAULT_EN.
- When defined, two extra outputs are added:
  - first_fault_valid (1 bit)
  - first_fault_idx (8 bits)
- On the cycle fault_sticky goes from all-zero to nonzero, first_fault_idx captures the lowest set bit index of the new fault_sticky, and first_fault_valid is set.
- Both hold until an sts_clear that leaves fault_sticky all-zero. Both reset to 0.
- When not defined, these ports and their logic do not exist, and behaviour is otherwise identical.

Test Plan:
1. Drive spi_running 0→1 and hold -> spi_running_stable rises exactly 6 edges after the first sampling edge; sts_update high for exactly 1 cycle on the following edge.
2. over_thresh[3] high for 1 aclk cycle only -> over_thresh_stable and fault_sticky stay 0; no sts_update.
3. over_thresh[3] high for 10 cycles, then low; later pulse sts_clear -> over_thresh_stable[3] rises then falls; fault_sticky[3]=1 and fault_any=1 until the clear; both 0 after.
4. sts_clear in the same cycle a newly filtered thresh_overflow[0] asserts -> fault_sticky[16] remains 1.
5. buf_words=0x0042 accepted; then toggle 0x0010/0x0011 every cycle for 20 cycles; then hold 0x0077 -> output stays 0x0042 during toggling; reads 0x0077 6 edges after the hold begins.
6. Assert aresetn low mid-filter with faults latched -> all outputs 0 immediately, without a clock edge. With SHIM_STS_FIRST_FAULT_EN, bad_trig_cmd as the first fault -> first_fault_idx=24, first_fault_valid=1.

Source files
------------

// File: rtl/shim_spi_sts_sync_if.sv
// shim_spi_sts_sync_if
//   Status bundle between the SPI-domain status sources and the AXI status
//   register block, passing through shim_spi_sts_sync.
//   slave  : the synchronizer (takes raw SPI status, produces filtered status)
//   master : the side driving raw status / sts_clear and reading results
//   Optional SHIM_STS_FIRST_FAULT_EN adds first_fault_valid / first_fault_idx.
interface shim_spi_sts_sync_if #(
  parameter int N_CH = 8
);
  // raw SPI-domain inputs (asynchronous to aclk) plus AXI-side clear
  logic                spi_running;
  logic [N_CH-1:0]     over_thresh;
  logic [N_CH-1:0]     thresh_underflow;
  logic [N_CH-1:0]     thresh_overflow;
  logic                bad_trig_cmd;
  logic [15:0]         buf_words;
  logic                sts_clear;
  // filtered AXI-domain outputs
  logic                spi_running_stable;
  logic [N_CH-1:0]     over_thresh_stable;
  logic [15:0]         buf_words_stable;
  logic [3*N_CH:0]     fault_sticky;
  logic                fault_any;
  logic                sts_update;
`ifdef SHIM_STS_FIRST_FAULT_EN
  logic                first_fault_valid;
  logic [7:0]          first_fault_idx;
`endif

  modport slave (
    input  spi_running, over_thresh, thresh_underflow, thresh_overflow,
           bad_trig_cmd, buf_words, sts_clear,
    output spi_running_stable, over_thresh_stable, buf_words_stable,
           fault_sticky, fault_any, sts_update
`ifdef SHIM_STS_FIRST_FAULT_EN
    , output first_fault_valid, first_fault_idx
`endif
  );

  modport master (
    output spi_running, over_thresh, thresh_underflow, thresh_overflow,
           bad_trig_cmd, buf_words, sts_clear,
    input  spi_running_stable, over_thresh_stable, buf_words_stable,
           fault_sticky, fault_any, sts_update
`ifdef SHIM_STS_FIRST_FAULT_EN
    , input first_fault_valid, first_fault_idx
`endif
  );
endinterface

// File: rtl/shim_spi_sts_sync.sv
// shim_spi_sts_sync
//   SPI -> AXI status return path. Each status field goes through a DEPTH-flop
//   synchronizer and a stability filter; a field is only accepted (atomically,
//   whole word) after holding the same value for STABLE_COUNT+1 cycles at the
//   synchronizer output. Fault fields are latched sticky until sts_clear.
//   Ports:
//     aclk, aresetn : only clock, async active-low reset
//     sts           : shim_spi_sts_sync_if.slave (raw status in, filtered out)
//   Optional: define SHIM_STS_FIRST_FAULT_EN to add first-fault capture
//   (first_fault_valid, first_fault_idx).

// Per-field synchronizer + stability filter. dout is the field's accepted value.
module shim_spi_sts_filt #(
  parameter int W            = 1,
  parameter int DEPTH        = 3,
  parameter int STABLE_COUNT = 2
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  localparam int            CW = $clog2(STABLE_COUNT + 1);
  localparam logic [CW-1:0] SC = CW'(STABLE_COUNT);

  logic [DEPTH-1:0][W-1:0] sync;
  logic [W-1:0]            last, prev;
  logic [CW-1:0]           cnt;
  logic                    equal, flag;

  assign last  = sync[DEPTH-1];
  assign equal = (last == prev);
  assign flag  = equal && (cnt == SC);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync <= '0;
      prev <= '0;
      cnt  <= '0;
      dout <= '0;
    end else begin
      sync <= {sync[DEPTH-2:0], din};   // sync[0] is the newest sample
      prev <= last;
      if (!equal)       cnt <= '0;
      else if (cnt < SC) cnt <= cnt + 1'b1;
      if (flag)         dout <= last;
    end
  end
endmodule

module shim_spi_sts_sync #(
  parameter int DEPTH        = 3,
  parameter int STABLE_COUNT = 2,
  parameter int N_CH         = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  shim_spi_sts_sync_if.slave    sts
);
  localparam int FW = 3*N_CH + 1;
  localparam int SW = 1 + N_CH + 16 + FW;   // everything that can raise sts_update

  logic            run_f, bt_f;
  logic [N_CH-1:0] ot_f, uf_f, of_f;
  logic [15:0]     bw_f;

  shim_spi_sts_filt #(.W(1),    .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_run (
    .aclk(aclk), .aresetn(aresetn), .din(sts.spi_running),      .dout(run_f));
  shim_spi_sts_filt #(.W(N_CH), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_ot (
    .aclk(aclk), .aresetn(aresetn), .din(sts.over_thresh),      .dout(ot_f));
  shim_spi_sts_filt #(.W(N_CH), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_uf (
    .aclk(aclk), .aresetn(aresetn), .din(sts.thresh_underflow), .dout(uf_f));
  shim_spi_sts_filt #(.W(N_CH), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_of (
    .aclk(aclk), .aresetn(aresetn), .din(sts.thresh_overflow),  .dout(of_f));
  shim_spi_sts_filt #(.W(1),    .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_bt (
    .aclk(aclk), .aresetn(aresetn), .din(sts.bad_trig_cmd),     .dout(bt_f));
  shim_spi_sts_filt #(.W(16),   .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_bw (
    .aclk(aclk), .aresetn(aresetn), .din(sts.buf_words),        .dout(bw_f));

  logic [FW-1:0] flt, sticky_q, sticky_nxt;
  logic [SW-1:0] snap, snap_q;
  logic          any_q, upd_q;

  assign flt        = {bt_f, of_f, uf_f, ot_f};
  // set wins over clear: a fault still filtered high re-asserts the bit
  assign sticky_nxt = (sticky_q & ~{FW{sts.sts_clear}}) | flt;
  assign snap       = {run_f, ot_f, bw_f, sticky_q};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sticky_q <= '0;
      any_q    <= 1'b0;
      snap_q   <= '0;
      upd_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_nxt;
      any_q    <= |sticky_q;
      snap_q   <= snap;
      // compare against last cycle's copy: one pulse per change cycle
      upd_q    <= (snap != snap_q);
    end
  end

  assign sts.spi_running_stable = run_f;
  assign sts.over_thresh_stable = ot_f;
  assign sts.buf_words_stable   = bw_f;
  assign sts.fault_sticky       = sticky_q;
  assign sts.fault_any          = any_q;
  assign sts.sts_update         = upd_q;

`ifdef SHIM_STS_FIRST_FAULT_EN
  logic       ff_vld;
  logic [7:0] ff_idx, ff_low;

  // lowest set bit of the value fault_sticky is about to take
  always_comb begin
    ff_low = '0;
    for (int i = FW-1; i >= 0; i--)
      if (sticky_nxt[i]) ff_low = 8'(i);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ff_vld <= 1'b0;
      ff_idx <= '0;
    end else if ((sticky_q == '0) && (sticky_nxt != '0)) begin
      ff_vld <= 1'b1;
      ff_idx <= ff_low;
    end else if (sts.sts_clear && (sticky_nxt == '0)) begin
      ff_vld <= 1'b0;
      ff_idx <= '0;
    end
  end

  assign sts.first_fault_valid = ff_vld;
  assign sts.first_fault_idx   = ff_idx;
`endif
endmodule

// File: tb/tb_shim_spi_sts_sync.sv
// Directed bench for shim_spi_sts_sync (defaults DEPTH=3, STABLE_COUNT=2, N_CH=8).
// Inputs change 1ns after a rising edge; outputs are sampled 1ns after an edge.
module tb_shim_spi_sts_sync;
  logic aclk;
  logic aresetn;
  int   vectors = 0;
  int   miscompares = 0;

  shim_spi_sts_sync_if #(.N_CH(8)) sts ();

  shim_spi_sts_sync #(.DEPTH(3), .STABLE_COUNT(2), .N_CH(8)) dut (
    .aclk(aclk), .aresetn(aresetn), .sts(sts));

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".run"},    32'(sts.spi_running_stable), 32'h0);
    chk({tag, ".ot"},     32'(sts.over_thresh_stable), 32'h0);
    chk({tag, ".bw"},     32'(sts.buf_words_stable),   32'h0);
    chk({tag, ".sticky"}, 32'(sts.fault_sticky),       32'h0);
    chk({tag, ".any"},    32'(sts.fault_any),          32'h0);
    chk({tag, ".upd"},    32'(sts.sts_update),         32'h0);
`ifdef SHIM_STS_FIRST_FAULT_EN
    chk({tag, ".ffv"},    32'(sts.first_fault_valid),  32'h0);
    chk({tag, ".ffi"},    32'(sts.first_fault_idx),    32'h0);
`endif
  endtask

  initial begin
    aresetn = 1'b1;
    sts.spi_running = 0; sts.over_thresh = '0; sts.thresh_underflow = '0;
    sts.thresh_overflow = '0; sts.bad_trig_cmd = 0; sts.buf_words = '0;
    sts.sts_clear = 0;
    #2 aresetn = 1'b0;
    tick(3);
    chk_all_zero("reset");
    aresetn = 1'b1;
    tick(10);
    chk_all_zero("post_reset");

    // 1: spi_running 0->1, first sampled on the next edge (E1); output at E7
    sts.spi_running = 1;
    tick(6);
    chk("run_e6",  32'(sts.spi_running_stable), 32'h0);
    tick(1);
    chk("run_e7",  32'(sts.spi_running_stable), 32'h1);
    chk("upd_e7",  32'(sts.sts_update),         32'h0);
    tick(1);
    chk("upd_e8",  32'(sts.sts_update),         32'h1);
    tick(1);
    chk("upd_e9",  32'(sts.sts_update),         32'h0);
    tick(3);

    // 2: one-cycle glitch on over_thresh[3] must be rejected
    sts.over_thresh = 8'h08;
    tick(1);
    sts.over_thresh = 8'h00;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("glitch_ot",     32'(sts.over_thresh_stable), 32'h0);
      chk("glitch_sticky", 32'(sts.fault_sticky),       32'h0);
      chk("glitch_upd",    32'(sts.sts_update),         32'h0);
    end

    // 3: over_thresh[3] held 10 cycles, later cleared
    sts.over_thresh = 8'h08;
    tick(7);
    chk("ot_rise",     32'(sts.over_thresh_stable), 32'h08);
    tick(1);
    chk("ot_sticky",   32'(sts.fault_sticky),       32'h08);
`ifdef SHIM_STS_FIRST_FAULT_EN
    chk("ot_ffv",      32'(sts.first_fault_valid),  32'h1);
    chk("ot_ffi",      32'(sts.first_fault_idx),    32'd3);
`endif
    tick(1);
    chk("ot_any",      32'(sts.fault_any),          32'h1);
    tick(1);
    sts.over_thresh = 8'h00;
    tick(7);
    chk("ot_fall",     32'(sts.over_thresh_stable), 32'h0);
    chk("ot_hold",     32'(sts.fault_sticky),       32'h08);
    tick(2);
    chk("ot_any_hold", 32'(sts.fault_any),          32'h1);
    sts.sts_clear = 1;
    tick(1);
    sts.sts_clear = 0;
    chk("ot_cleared",  32'(sts.fault_sticky),       32'h0);
`ifdef SHIM_STS_FIRST_FAULT_EN
    chk("ot_ffv_clr",  32'(sts.first_fault_valid),  32'h0);
`endif
    tick(1);
    chk("ot_any_clr",  32'(sts.fault_any),          32'h0);
    tick(3);

    // 4: clear sampled on the same edge the filtered overflow[0] first sets
    sts.thresh_overflow = 8'h01;
    tick(7);
    sts.sts_clear = 1;
    tick(1);
    sts.sts_clear = 0;
    chk("of_setwins",  32'(sts.fault_sticky),       32'h0001_0000);
    sts.thresh_overflow = 8'h00;
    tick(9);
    chk("of_hold",     32'(sts.fault_sticky),       32'h0001_0000);
    sts.sts_clear = 1;
    tick(1);
    sts.sts_clear = 0;
    chk("of_cleared",  32'(sts.fault_sticky),       32'h0);
    tick(3);

    // 5: buf_words accept, toggle (rejected), then new hold
    sts.buf_words = 16'h0042;
    tick(7);
    chk("bw_42",       32'(sts.buf_words_stable),   32'h0042);
    for (int i = 0; i < 20; i++) begin
      sts.buf_words = (i % 2 == 0) ? 16'h0010 : 16'h0011;
      tick(1);
      chk("bw_toggle", 32'(sts.buf_words_stable),   32'h0042);
    end
    sts.buf_words = 16'h0077;
    tick(6);
    chk("bw_e6",       32'(sts.buf_words_stable),   32'h0042);
    tick(1);
    chk("bw_77",       32'(sts.buf_words_stable),   32'h0077);
    tick(3);

    // 6: bad_trig_cmd fault, then async reset mid-filter
    sts.bad_trig_cmd = 1;
    tick(8);
    chk("bt_sticky",   32'(sts.fault_sticky),       32'h0100_0000);
`ifdef SHIM_STS_FIRST_FAULT_EN
    chk("bt_ffv",      32'(sts.first_fault_valid),  32'h1);
    chk("bt_ffi",      32'(sts.first_fault_idx),    32'd24);
`endif
    tick(1);
    chk("bt_any",      32'(sts.fault_any),          32'h1);
    sts.buf_words = 16'h1234;
    tick(2);
    #1 aresetn = 1'b0;
    #1 chk_all_zero("async_rst");
    sts.bad_trig_cmd = 0;
    @(posedge aclk);
    #1 aresetn = 1'b1;
    tick(6);
    chk("rst_bw_e6",   32'(sts.buf_words_stable),   32'h0);
    chk("rst_run_e6",  32'(sts.spi_running_stable), 32'h0);
    tick(1);
    chk("rst_bw_e7",   32'(sts.buf_words_stable),   32'h1234);
    chk("rst_run_e7",  32'(sts.spi_running_stable), 32'h1);
    chk("rst_sticky",  32'(sts.fault_sticky),       32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
